// File: rtl/mem_stage.sv
// mem_stage: doubleword ld/sd stage with an internal data memory and a fixed LATENCY-cycle access time.
// Optional MEM_MISALIGN_TRAP_EN: misaligned memory ops complete with misaligned=1, wb_data=0 and no write.
module mem_stage #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [63:0] alu_result,
   input  logic [63:0] read_data2,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemtoReg,
   output logic        stall,
   output logic        valid_out,
   output logic [63:0] wb_data,
   output logic        misaligned
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [63:0] addr_q;
   logic [63:0] data_q;
   logic        wr_q;
   logic        m2r_q;
   logic        valid_q;
   logic        mis_q;
   logic [63:0] wb_q;

   logic [63:0] mem [DEPTH];

   logic          accept_d;
   logic          mem_op_d;
   logic [AW-1:0] idx_d;
   logic          trap_d;
   logic          wr_en_d;
   logic [63:0]   rd_dat_d;

   assign accept_d = valid_in && (state_q == IDLE);
   assign mem_op_d = MemRead || MemWrite;
   assign idx_d    = addr_q[AW+2:3];
   assign rd_dat_d = mem[idx_d];

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap_d = (addr_q[2:0] != 3'd0);
`else
   assign trap_d = 1'b0;
`endif

   // A reset arriving on the DONE edge aborts the store as well as the FSM.
   assign wr_en_d = (state_q == DONE) && wr_q && !trap_d && !reset;

   always_ff @(posedge clk) begin
      if (wr_en_d) begin
         mem[idx_d] <= data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 64'd0;
         data_q  <= 64'd0;
         wr_q    <= 1'b0;
         m2r_q   <= 1'b0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         wb_q    <= 64'd0;
      end else begin
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  addr_q <= alu_result;
                  data_q <= read_data2;
                  wr_q   <= MemWrite;
                  m2r_q  <= MemtoReg;
                  if (!mem_op_d) begin
                     valid_q <= 1'b1;
                     wb_q    <= alu_result;
                  end else if (LATENCY == 0) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= 4'(LATENCY);
                  end
               end
            end
            BUSY: begin
               if (cnt_q == 4'd1) begin
                  state_q <= DONE;
               end
               cnt_q <= cnt_q - 4'd1;
            end
            DONE: begin
               state_q <= IDLE;
               valid_q <= 1'b1;
               mis_q   <= trap_d;
               // ld+sd together behaves as a store, so a store never returns memory data.
               if (trap_d) begin
                  wb_q <= 64'd0;
               end else if (m2r_q && !wr_q) begin
                  wb_q <= rd_dat_d;
               end else begin
                  wb_q <= addr_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall      = (state_q != IDLE);
   assign valid_out  = valid_q;
   assign wb_data    = wb_q;
   assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver queues expected results, monitor checks each valid_out pulse.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [63:0] alu_result;
   logic [63:0] read_data2;
   logic        MemRead;
   logic        MemWrite;
   logic        MemtoReg;
   logic        stall;
   logic        valid_out;
   logic [63:0] wb_data;
   logic        misaligned;

   always #5 clk = ~clk;

   mem_stage #(.DEPTH(256), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .alu_result (alu_result),
      .read_data2 (read_data2),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .MemtoReg   (MemtoReg),
      .stall      (stall),
      .valid_out  (valid_out),
      .wb_data    (wb_data),
      .misaligned (misaligned)
   );

   typedef struct packed {
      logic [63:0] wb;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec   = 0;
   int   n_err   = 0;
   int   n_pulse = 0;
   int   n_push  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid_out === 1'b1) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_valid_out: got wb_data %h, expected no output", wb_data);
            end else begin
               e = exp_q.pop_front();
               check("wb_data", wb_data, e.wb);
               check("misaligned", 64'(misaligned), 64'(e.mis));
            end
         end
      end
   end

   task automatic push(input logic [63:0] wb, input logic mis);
      exp_t e;
      e.wb  = wb;
      e.mis = mis;
      exp_q.push_back(e);
      n_push++;
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] d,
                        input logic rd, input logic wr, input logic m2r);
      @(negedge clk);
      valid_in   = 1'b1;
      alu_result = a;
      read_data2 = d;
      MemRead    = rd;
      MemWrite   = wr;
      MemtoReg   = m2r;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
   endtask

   // Counts stalled cycles after an accept; bounded so a stuck FSM still reaches the summary.
   task automatic wait_idle(input string name, input int exp_cycles);
      int c;
      c = 0;
      @(negedge clk);
      while (stall === 1'b1 && c < 40) begin
         c++;
         @(negedge clk);
      end
      check(name, 64'(c), 64'(exp_cycles));
   endtask

   task automatic op(input string name, input logic [63:0] a, input logic [63:0] d,
                     input logic rd, input logic wr, input logic m2r,
                     input logic [63:0] exp_wb, input logic exp_mis, input int exp_stall);
      push(exp_wb, exp_mis);
      drive(a, d, rd, wr, m2r);
      wait_idle(name, exp_stall);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      valid_in   = 1'b0;
      alu_result = 64'd0;
      read_data2 = 64'd0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_stall", 64'(stall), 64'd0);
      check("reset_valid_out", 64'(valid_out), 64'd0);
      check("reset_wb_data", wb_data, 64'd0);
      check("reset_misaligned", 64'(misaligned), 64'd0);

      op("alu_stall", 64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 64'h1234, 1'b0, 0);
      op("alu_all_ones_stall", 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 1'b0, 1'b0, 1'b0,
         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);

      // Back-to-back ALU ops on consecutive edges.
      push(64'hA1, 1'b0);
      push(64'hB2, 1'b0);
      @(negedge clk);
      valid_in   = 1'b1;
      alu_result = 64'hA1;
      @(posedge clk);
      #1 alu_result = 64'hB2;
      @(posedge clk);
      #1 valid_in = 1'b0;
      wait_idle("alu_b2b_stall", 0);

      op("sd_40_stall", 64'h40, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1, 1'b0, 64'h40, 1'b0, 3);
      op("ld_40_stall", 64'h40, 64'd0, 1'b1, 1'b0, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, 3);
      op("ld_40_noreg_stall", 64'h40, 64'd0, 1'b1, 1'b0, 1'b0, 64'h40, 1'b0, 3);

      op("sd_800_stall", 64'h800, 64'd7, 1'b0, 1'b1, 1'b0, 64'h800, 1'b0, 3);
      op("ld_0_wrap_stall", 64'h0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd7, 1'b0, 3);

      op("sd_top_stall", 64'h7F8, 64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0, 64'h7F8, 1'b0, 3);
      op("ld_top_stall", 64'h7F8, 64'd0, 1'b1, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0, 3);

      op("rdwr_stall", 64'h10, 64'h55, 1'b1, 1'b1, 1'b1, 64'h10, 1'b0, 3);
      op("ld_10_stall", 64'h10, 64'd0, 1'b1, 1'b0, 1'b1, 64'h55, 1'b0, 3);

      // Extra valid_in held across two stalled edges must be dropped.
      push(64'h18, 1'b0);
      @(negedge clk);
      valid_in   = 1'b1;
      alu_result = 64'h18;
      read_data2 = 64'h99;
      MemWrite   = 1'b1;
      @(posedge clk);
      #1;
      alu_result = 64'h999;
      MemWrite   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 valid_in = 1'b0;
      wait_idle("holdoff_stall", 1);
      op("ld_18_stall", 64'h18, 64'd0, 1'b1, 1'b0, 1'b1, 64'h99, 1'b0, 3);

      // Store aborted by reset in its first BUSY cycle.
      drive(64'h0, 64'd5, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("midop_busy_stall", 64'(stall), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midop_reset_stall", 64'(stall), 64'd0);
      check("midop_reset_wb_data", wb_data, 64'd0);
      op("ld_0_after_abort_stall", 64'h0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd7, 1'b0, 3);

`ifdef MEM_MISALIGN_TRAP_EN
      op("sd_43_trap_stall", 64'h43, 64'hAB, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 3);
      op("ld_40_after_trap_stall", 64'h40, 64'd0, 1'b1, 1'b0, 1'b1,
         64'hDEADBEEFCAFEF00D, 1'b0, 3);
`else
      op("ld_45_trunc_stall", 64'h45, 64'd0, 1'b1, 1'b0, 1'b1,
         64'hDEADBEEFCAFEF00D, 1'b0, 3);
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("pulse_count", 64'(n_pulse), 64'(n_push));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
